sipo_rx_ctrl: RTL and testbench
===============================

Name: sipo_rx_ctrl

Overview:
Framing controller that sequences a right-shifting serial-in/parallel-out register to receive fixed-width words LSB-first. It counts bits, handles frame start, restart and inter-bit timeout, and hands completed words to a consumer through a one-deep output buffer with a valid/ready handshake. It sits between a serial bit source (pin sampler or deserialiser front end) and the word-level datapath.

Parameters:
WIDTH, 8, bits per frame / output word width (>=2)
TOUT, 16, consecutive cycles in SHIFT without bit_vld_i before the partial frame is aborted (>=1)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
start_i  input  1  frame start strobe
bit_i  input  1  serial data bit
bit_vld_i  input  1  bit_i valid this cycle
word_o  output  WIDTH  received word (output buffer)
word_vld_o  output  1  word_o valid
word_rdy_i  input  1  consumer accepts word_o
busy_o  output  1  high while in SHIFT
ovr_o  output  1  sticky overrun flag
tout_o  output  1  one-cycle timeout pulse
clr_i  input  1  clears ovr_o

Behaviour:
- Reset (async, rst_i=1): state=IDLE, shift reg=0, bit count=0, idle timer=0, word_o=0, word_vld_o=0, ovr_o=0, tout_o=0, busy_o=0.
- States: IDLE, SHIFT. busy_o = (state==SHIFT), registered with the state.
- IDLE: bit_vld_i ignored. start_i=1 -> SHIFT, count=0, timer=0. The start cycle never samples a bit.
- SHIFT, priority start_i > bit_vld_i > timeout:
  - start_i=1: restart; count=0, timer=0, partial data discarded, stay in SHIFT, no flag.
  - bit_vld_i=1: shreg <= {bit_i, shreg[WIDTH-1:1]}, count+1, timer=0. The first received bit lands in word bit 0.
  - Neither: timer+1. When the timer reaches TOUT-1 with no bit that cycle -> IDLE, tout_o=1 for exactly one cycle, partial frame discarded.
- Frame completion: the bit_vld_i cycle with count==WIDTH-1 completes the frame. In the same edge, state -> IDLE and the full word {bit_i, shreg[WIDTH-1:1]} is offered to the output buffer. word_vld_o asserts the cycle after the last bit is sampled (latency 1).
- Output buffer load rule: load if word_vld_o==0 or (word_vld_o && word_rdy_i) in that cycle. If loaded, word_vld_o stays or becomes 1.
- Overrun: if the buffer is full and not popped, the new word is dropped, word_o and word_vld_o are unchanged, and ovr_o <= 1.
- Handshake: a transfer occurs when word_vld_o && word_rdy_i. Without a new load, word_vld_o -> 0 next cycle. word_o is stable while word_vld_o=1 and not popped. word_rdy_i is ignored when word_vld_o=0.
- ovr_o is sticky until clr_i=1. If clr_i and a new overrun occur in the same cycle, set wins.
- tout_o is 0 in all cycles except the timeout pulse.
- start_i in the completion cycle: the restart takes priority, the final bit is not shifted and no word is produced.
- Counter width is clog2(WIDTH). Timer width is clog2(TOUT)+1. No wrap is possible because both counters are cleared on exit.
- Reset mid-frame or with word_vld_o=1: everything clears immediately. The pending word is lost and no flag is raised.

Test Plan:
- WIDTH=8, rdy=1: start, then 8 consecutive valid bits 1,0,1,0,0,1,0,1 -> word_o=0xA5 with word_vld_o=1 for exactly 1 cycle, one cycle after the 8th bit; busy_o falls the same cycle.
- Gapped bits: 0xC3 LSB-first with 3-cycle gaps (< TOUT) -> word_o=0xC3. Then start plus 3 bits followed by 16 idle cycles -> tout_o single pulse on the 16th idle cycle, busy_o=0, no word.
- Backpressure: rdy=0, receive 0x11 then 0x22 -> word_o stays 0x11, ovr_o=1. Raise rdy -> 0x11 accepted, word_vld_o=0. Pulse clr_i -> ovr_o=0.
- Simultaneous pop and load: word 0x5A pending, last bit of 0x3C arrives with rdy=1 -> next cycle word_o=0x3C, word_vld_o=1, ovr_o=0.
- Restart: 5 bits of garbage, start_i, then 8 bits of 0x96 -> single word 0x96. start_i asserted on an 8th-bit cycle -> no word produced.
- Async reset asserted mid-frame with a word pending (off-edge) -> all outputs 0 immediately. Bits without a start after reset are ignored.

Source files
------------

// File: rtl/sipo_rx_ctrl.sv
// sipo_rx_ctrl: frames LSB-first serial bits into words and buffers them behind a valid/ready handshake
module sipo_rx_ctrl #(
   parameter int WIDTH = 8,
   parameter int TOUT  = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             bit_i,
   input  logic             bit_vld_i,
   output logic [WIDTH-1:0] word_o,
   output logic             word_vld_o,
   input  logic             word_rdy_i,
   output logic             busy_o,
   output logic             ovr_o,
   output logic             tout_o,
   input  logic             clr_i
);
   localparam int CW = $clog2(WIDTH);
   localparam int TW = $clog2(TOUT) + 1;
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic [TW-1:0]    timer;
   logic [WIDTH-1:0] next_word;
   logic             done;
   logic             load;

   assign next_word = {bit_i, shreg[WIDTH-1:1]};
   // a restart in the last-bit cycle wins, so completion requires start_i low
   assign done      = (state == S_SHIFT) && !start_i && bit_vld_i && (cnt == CW'(WIDTH-1));
   assign load      = done && (!word_vld_o || word_rdy_i);
   assign busy_o    = (state == S_SHIFT);

   // framing: start/restart, bit shifting, completion and inter-bit timeout
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= S_IDLE;
         shreg  <= '0;
         cnt    <= '0;
         timer  <= '0;
         tout_o <= 1'b0;
      end else begin
         tout_o <= 1'b0;
         if (state == S_IDLE) begin
            if (start_i) begin
               state <= S_SHIFT;
               cnt   <= '0;
               timer <= '0;
            end
         end else if (start_i) begin
            cnt   <= '0;
            timer <= '0;
         end else if (bit_vld_i) begin
            shreg <= next_word;
            timer <= '0;
            cnt   <= done ? '0 : cnt + 1'b1;
            if (done) state <= S_IDLE;
         end else if (timer == TW'(TOUT-1)) begin
            state  <= S_IDLE;
            tout_o <= 1'b1;
            cnt    <= '0;
            timer  <= '0;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

   // one-deep output buffer; a full, unpopped buffer drops the new word and flags overrun
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         word_o     <= '0;
         word_vld_o <= 1'b0;
         ovr_o      <= 1'b0;
      end else begin
         if (load) begin
            word_o     <= next_word;
            word_vld_o <= 1'b1;
         end else if (word_vld_o && word_rdy_i) begin
            word_vld_o <= 1'b0;
         end
         if (done && !load) ovr_o <= 1'b1;
         else if (clr_i) ovr_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// tb_sipo_rx_ctrl: directed and randomized checks of sipo_rx_ctrl against a bit-queue reference model
module tb_sipo_rx_ctrl;
   localparam int WIDTH = 8;
   localparam int TOUT  = 16;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b1;
   logic             start_i = 1'b0;
   logic             bit_i = 1'b0;
   logic             bit_vld_i = 1'b0;
   logic [WIDTH-1:0] word_o;
   logic             word_vld_o;
   logic             word_rdy_i = 1'b0;
   logic             busy_o;
   logic             ovr_o;
   logic             tout_o;
   logic             clr_i = 1'b0;

   int n_pass = 0;
   int n_tot  = 0;

   sipo_rx_ctrl #(.WIDTH(WIDTH), .TOUT(TOUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .bit_i(bit_i),
      .bit_vld_i(bit_vld_i), .word_o(word_o), .word_vld_o(word_vld_o),
      .word_rdy_i(word_rdy_i), .busy_o(busy_o), .ovr_o(ovr_o),
      .tout_o(tout_o), .clr_i(clr_i)
   );

   always #5 clk_i = ~clk_i;

   // reference model: collected bits in a queue, idle cycles as a plain count
   logic             m_busy, m_vld, m_ovr, m_tout;
   logic [WIDTH-1:0] m_word;
   logic             q[$];
   int               idle;

   always @(posedge clk_i or posedge rst_i) begin
      logic             got, pop;
      logic [WIDTH-1:0] w;
      if (rst_i) begin
         m_busy = 0; m_vld = 0; m_ovr = 0; m_tout = 0; m_word = '0; idle = 0; q.delete();
      end else begin
         got = 0; w = '0; pop = m_vld && word_rdy_i; m_tout = 0;
         if (!m_busy) begin
            if (start_i) begin m_busy = 1; q.delete(); idle = 0; end
         end else if (start_i) begin
            q.delete(); idle = 0;
         end else if (bit_vld_i) begin
            q.push_back(bit_i); idle = 0;
            if (q.size() == WIDTH) begin
               for (int i = 0; i < WIDTH; i++) w[i] = q[i];
               got = 1; m_busy = 0; q.delete();
            end
         end else begin
            idle++;
            if (idle == TOUT) begin m_busy = 0; m_tout = 1; q.delete(); idle = 0; end
         end
         if (got && m_vld && !pop) m_ovr = 1;
         else if (clr_i) m_ovr = 0;
         if (got && (!m_vld || pop)) begin m_word = w; m_vld = 1; end
         else if (pop) m_vld = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk_i) begin
      if (!rst_i) begin
         chk("m_vld",  32'(word_vld_o), 32'(m_vld));
         chk("m_word", 32'(word_o),     32'(m_word));
         chk("m_busy", 32'(busy_o),     32'(m_busy));
         chk("m_ovr",  32'(ovr_o),      32'(m_ovr));
         chk("m_tout", 32'(tout_o),     32'(m_tout));
      end
   end

   task automatic cyc(input logic s, input logic v, input logic b);
      start_i = s; bit_vld_i = v; bit_i = b;
      @(negedge clk_i);
   endtask

   task automatic send(input logic [WIDTH-1:0] w);
      cyc(1, 0, 0);
      for (int i = 0; i < WIDTH; i++) cyc(0, 1, w[i]);
   endtask

   initial begin
      logic [WIDTH-1:0] w;
      int pv;
      @(negedge clk_i);
      chk("rst_vld", 32'(word_vld_o), 0);
      chk("rst_word", 32'(word_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      rst_i = 1'b0;
      word_rdy_i = 1'b1;
      @(negedge clk_i);
      // 0xA5 back-to-back
      cyc(1, 0, 0);
      chk("a5_busy_start", 32'(busy_o), 1);
      w = 8'hA5;
      for (int i = 0; i < WIDTH; i++) cyc(0, 1, w[i]);
      chk("a5_vld", 32'(word_vld_o), 1);
      chk("a5_word", 32'(word_o), 32'hA5);
      chk("a5_busy", 32'(busy_o), 0);
      cyc(0, 0, 0);
      chk("a5_vld_drop", 32'(word_vld_o), 0);
      // 0xC3 with 3-cycle gaps
      cyc(1, 0, 0);
      w = 8'hC3;
      for (int i = 0; i < WIDTH; i++) begin
         cyc(0, 1, w[i]);
         if (i != WIDTH-1) repeat (3) cyc(0, 0, 0);
      end
      chk("c3_word", 32'(word_o), 32'hC3);
      chk("c3_vld", 32'(word_vld_o), 1);
      cyc(0, 0, 0);
      // partial frame then timeout
      cyc(1, 0, 0);
      repeat (3) cyc(0, 1, 1);
      repeat (TOUT-1) cyc(0, 0, 0);
      chk("to_busy_before", 32'(busy_o), 1);
      chk("to_tout_before", 32'(tout_o), 0);
      cyc(0, 0, 0);
      chk("to_tout", 32'(tout_o), 1);
      chk("to_busy", 32'(busy_o), 0);
      cyc(0, 0, 0);
      chk("to_tout_clear", 32'(tout_o), 0);
      chk("to_noword", 32'(word_vld_o), 0);
      // backpressure and overrun
      word_rdy_i = 1'b0;
      send(8'h11);
      send(8'h22);
      chk("bp_word", 32'(word_o), 32'h11);
      chk("bp_ovr", 32'(ovr_o), 1);
      word_rdy_i = 1'b1;
      cyc(0, 0, 0);
      chk("bp_pop", 32'(word_vld_o), 0);
      chk("bp_ovr_sticky", 32'(ovr_o), 1);
      clr_i = 1'b1;
      cyc(0, 0, 0);
      clr_i = 1'b0;
      chk("bp_clr", 32'(ovr_o), 0);
      // simultaneous pop and load
      word_rdy_i = 1'b0;
      send(8'h5A);
      cyc(1, 0, 0);
      w = 8'h3C;
      for (int i = 0; i < WIDTH-1; i++) cyc(0, 1, w[i]);
      chk("pl_hold", 32'(word_o), 32'h5A);
      word_rdy_i = 1'b1;
      cyc(0, 1, w[WIDTH-1]);
      chk("pl_word", 32'(word_o), 32'h3C);
      chk("pl_vld", 32'(word_vld_o), 1);
      chk("pl_ovr", 32'(ovr_o), 0);
      cyc(0, 0, 0);
      // restart discards garbage
      cyc(1, 0, 0);
      repeat (5) cyc(0, 1, 1);
      send(8'h96);
      chk("rs_word", 32'(word_o), 32'h96);
      chk("rs_vld", 32'(word_vld_o), 1);
      cyc(0, 0, 0);
      // restart on the final bit produces nothing
      cyc(1, 0, 0);
      repeat (WIDTH-1) cyc(0, 1, 0);
      cyc(1, 1, 1);
      chk("rs8_novld", 32'(word_vld_o), 0);
      chk("rs8_busy", 32'(busy_o), 1);
      repeat (TOUT+1) cyc(0, 0, 0);
      // async reset mid-frame with a pending word and overrun
      word_rdy_i = 1'b0;
      send(8'h77);
      send(8'h78);
      cyc(1, 0, 0);
      repeat (3) cyc(0, 1, 1);
      #2 rst_i = 1'b1;
      #1;
      chk("ar_vld", 32'(word_vld_o), 0);
      chk("ar_word", 32'(word_o), 0);
      chk("ar_busy", 32'(busy_o), 0);
      chk("ar_ovr", 32'(ovr_o), 0);
      @(negedge clk_i);
      rst_i = 1'b0;
      repeat (12) cyc(0, 1, 1);
      chk("ar_nostart_busy", 32'(busy_o), 0);
      chk("ar_nostart_vld", 32'(word_vld_o), 0);
      // randomized traffic
      for (int blk = 0; blk < 6; blk++) begin
         pv = (blk % 2 == 1) ? 10 : 2;
         for (int i = 0; i < 500; i++) begin
            word_rdy_i = ($urandom_range(0, 1) == 1);
            clr_i = ($urandom_range(0, 19) == 0);
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, pv-1) == 0), ($urandom_range(0, 1) == 1));
         end
      end
      clr_i = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
